pc_sequencer: RTL and testbench

Program-counter sequencer for the SPr430 core: generates the 20-bit fetch address each CLK2 cycle, resolves JMP/CALL/RET from decode, and drives the 4-entry return-address stack directly downstream. It pushes return addresses on CALL and pops them on RET. It tracks stack occupancy so stack overflow and underflow are detected in one place. A one-cycle bubble (FLUSH) follows every taken control transfer.

---
 rtl/pc_seq_pkg.sv | 21 ++
 rtl/pc_sequencer_if.sv | 32 +++
 rtl/pc_seq_depth.sv | 28 ++
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package pc_seq_pkg;

  typedef logic [19:0] addr_t;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    BUBBLE
  } seq_state_t;

  localparam addr_t RESET_VEC_DEF   = 20'h00000;
  localparam addr_t TRAP_VEC_DEF    = 20'hFFFF0;
  localparam int    STACK_DEPTH_DEF = 4;

  // Sequential fetch address; wraps 20'hFFFFF -> 0.
  function automatic addr_t addr_inc(input addr_t a);
    return a + 20'd1;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode / return-stack / fetch bundle of the PC sequencer.
// master: decode and stack side; slave: the sequencer.
interface pc_sequencer_if;
  import pc_seq_pkg::*;

  logic       stall;
  logic       ins_vld;
  logic       jmp;
  logic       cond;
  logic       call;
  logic       ret;
  addr_t      tgt;
  addr_t      stk_do;
  addr_t      pc;
  addr_t      stk_di;
  logic       stk_ena;
  logic       stk_rts;
  logic       flush;
  logic [2:0] depth;
  logic       fault;

  modport master (
    output stall, ins_vld, jmp, cond, call, ret, tgt, stk_do,
    input  pc, stk_di, stk_ena, stk_rts, flush, depth, fault
  );

  modport slave (
    input  stall, ins_vld, jmp, cond, call, ret, tgt, stk_do,
    output pc, stk_di, stk_ena, stk_rts, flush, depth, fault
  );

endinterface

// File: rtl/pc_seq_depth.sv
// Return-stack occupancy counter, saturating at 0 and MAX.
module pc_seq_depth #(
  parameter int MAX = 4
) (
  input  logic       clk2,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  output logic [2:0] depth,
  output logic       full,
  output logic       empty
);

  assign full  = (depth == 3'(MAX));
  assign empty = (depth == 3'd0);

  // Count pushes up and pops down; never step past either bound.
  always_ff @(posedge clk2) begin
    if (rst) begin
      depth <= 3'd0;
    end else if (inc && !dec && !full) begin
      depth <= depth + 3'd1;
    end else if (dec && !inc && !empty) begin
      depth <= depth - 3'd1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch address, JMP/CALL/RET resolution,
// return-stack strobes and fault detection.
// Build option PC_SEQ_TRAP_EN: stack faults redirect fetch to TRAP_VEC.
//
// state  | meaning
// BOOT   | first cycle after reset, fetch slot flushed
// RUN    | normal fetch, decode inputs accepted
// BUBBLE | slot after a taken transfer, fetched word discarded
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter addr_t RESET_VEC   = RESET_VEC_DEF,
`ifdef PC_SEQ_TRAP_EN
  parameter addr_t TRAP_VEC    = TRAP_VEC_DEF,
`endif
  parameter int    STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic           clk2,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);

  seq_state_t state_q, state_nxt;
  addr_t      pc_q, pc_nxt;
  addr_t      pc_dec_q, pc_dec_nxt;
  logic       flush_q;
  logic       fault_q, fault_set;
  logic       stk_ena, stk_rts;
  logic       inc, dec, full, empty;
  logic [2:0] depth;

  pc_seq_depth #(.MAX(STACK_DEPTH)) u_depth (
    .clk2  (clk2),
    .rst   (rst),
    .inc   (inc),
    .dec   (dec),
    .depth (depth),
    .full  (full),
    .empty (empty)
  );

  // Next-state, next-PC and stack strobes; a taken transfer leaves
  // pc_dec alone so the decode address catches up during BUBBLE.
  always_comb begin
    state_nxt  = state_q;
    pc_nxt     = pc_q;
    pc_dec_nxt = pc_dec_q;
    stk_ena    = 1'b0;
    stk_rts    = 1'b0;
    inc        = 1'b0;
    dec        = 1'b0;
    fault_set  = 1'b0;
    if (!bus.stall) begin
      pc_nxt     = addr_inc(pc_q);
      pc_dec_nxt = pc_q;
      case (state_q)
        BOOT, BUBBLE: state_nxt = RUN;
        RUN: begin
          if (bus.ins_vld) begin
            if (bus.ret) begin
              if (!empty) begin
                stk_rts    = 1'b1;
                dec        = 1'b1;
                pc_nxt     = bus.stk_do;
                pc_dec_nxt = pc_dec_q;
                state_nxt  = BUBBLE;
              end else begin
                fault_set = 1'b1;
`ifdef PC_SEQ_TRAP_EN
                pc_nxt     = TRAP_VEC;
                pc_dec_nxt = pc_dec_q;
                state_nxt  = BUBBLE;
`endif
              end
            end else if (bus.call) begin
              pc_nxt     = bus.tgt;
              pc_dec_nxt = pc_dec_q;
              state_nxt  = BUBBLE;
              if (!full) begin
                stk_ena = 1'b1;
                inc     = 1'b1;
              end else begin
                fault_set = 1'b1;
`ifdef PC_SEQ_TRAP_EN
                pc_nxt = TRAP_VEC;
`endif
              end
            end else if (bus.jmp && bus.cond) begin
              pc_nxt     = bus.tgt;
              pc_dec_nxt = pc_dec_q;
              state_nxt  = BUBBLE;
            end
          end
        end
        default: state_nxt = BOOT;
      endcase
    end
    // A reset cycle must not disturb the stack.
    if (rst) begin
      stk_ena = 1'b0;
      stk_rts = 1'b0;
      inc     = 1'b0;
      dec     = 1'b0;
    end
  end

  // State, PC pair, registered flush and sticky fault.
  always_ff @(posedge clk2) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_q     <= RESET_VEC;
      pc_dec_q <= RESET_VEC;
      flush_q  <= 1'b1;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      pc_q     <= pc_nxt;
      pc_dec_q <= pc_dec_nxt;
      if (!bus.stall) begin
        flush_q <= (state_nxt != RUN);
      end
      fault_q <= fault_q | fault_set;
    end
  end

  assign bus.pc      = pc_q;
  assign bus.stk_di  = addr_inc(pc_dec_q);
  assign bus.stk_ena = stk_ena;
  assign bus.stk_rts = stk_rts;
  assign bus.flush   = flush_q;
  assign bus.depth   = depth;
  assign bus.fault   = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; expectations follow the build option
// PC_SEQ_TRAP_EN when it is defined.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic clk2;
  logic rst;
  int   n_chk;
  int   n_fail;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk2 (clk2),
    .rst  (rst),
    .bus  (bus)
  );

`ifdef PC_SEQ_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  task automatic clear();
    bus.stall   = 1'b0;
    bus.ins_vld = 1'b0;
    bus.jmp     = 1'b0;
    bus.cond    = 1'b0;
    bus.call    = 1'b0;
    bus.ret     = 1'b0;
    bus.tgt     = 20'h0;
    bus.stk_do  = 20'h0;
  endtask

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  initial begin
    logic [19:0] p0;
    n_chk  = 0;
    n_fail = 0;
    clear();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // reset state, BOOT cycle
    chk("rst_pc", bus.pc, 20'h0);
    chk("rst_flush", 20'(bus.flush), 20'h1);
    chk("rst_depth", 20'(bus.depth), 20'h0);
    chk("rst_fault", 20'(bus.fault), 20'h0);
    chk("rst_ena", 20'(bus.stk_ena), 20'h0);
    chk("rst_rts", 20'(bus.stk_rts), 20'h0);
    chk("rst_di", bus.stk_di, 20'h1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("idle_pc", bus.pc, 20'(i));
      chk("idle_flush", 20'(bus.flush), 20'h0);
    end
    tick();
    tick();
    chk("pre_jmp_pc", bus.pc, 20'h6);

    // taken jump at pc_d = 5
    bus.ins_vld = 1'b1; bus.jmp = 1'b1; bus.cond = 1'b1; bus.tgt = 20'h00100;
    #1 chk("jmp_ena", 20'(bus.stk_ena), 20'h0);
    tick();
    clear();
    chk("jmp_pc", bus.pc, 20'h00100);
    chk("jmp_flush", 20'(bus.flush), 20'h1);
    tick();
    chk("jmp_pc2", bus.pc, 20'h00101);
    chk("jmp_flush2", 20'(bus.flush), 20'h0);

    // not-taken jump
    bus.ins_vld = 1'b1; bus.jmp = 1'b1; bus.cond = 1'b0; bus.tgt = 20'h00300;
    tick();
    clear();
    chk("nt_pc", bus.pc, 20'h00102);
    chk("nt_flush", 20'(bus.flush), 20'h0);

    // steer pc_d to 0x10
    bus.ins_vld = 1'b1; bus.jmp = 1'b1; bus.cond = 1'b1; bus.tgt = 20'h00010;
    tick();
    clear();
    tick();
    chk("steer_pc", bus.pc, 20'h00011);

    // call at pc_d = 0x10
    bus.ins_vld = 1'b1; bus.call = 1'b1; bus.tgt = 20'h00200;
    #1;
    chk("call_ena", 20'(bus.stk_ena), 20'h1);
    chk("call_di", bus.stk_di, 20'h00011);
    chk("call_rts", 20'(bus.stk_rts), 20'h0);
    tick();
    clear();
    chk("call_pc", bus.pc, 20'h00200);
    chk("call_depth", 20'(bus.depth), 20'h1);
    chk("call_flush", 20'(bus.flush), 20'h1);
    tick();

    // return
    bus.ins_vld = 1'b1; bus.ret = 1'b1; bus.stk_do = 20'h00011;
    #1;
    chk("ret_rts", 20'(bus.stk_rts), 20'h1);
    chk("ret_ena", 20'(bus.stk_ena), 20'h0);
    tick();
    clear();
    chk("ret_pc", bus.pc, 20'h00011);
    chk("ret_depth", 20'(bus.depth), 20'h0);
    tick();
    chk("ret_pc2", bus.pc, 20'h00012);

    // four nested calls fill the stack
    for (int k = 0; k < 4; k++) begin
      bus.ins_vld = 1'b1; bus.call = 1'b1; bus.tgt = 20'h00400 + 20'(k * 16);
      #1 chk("nest_ena", 20'(bus.stk_ena), 20'h1);
      tick();
      chk("nest_pc", bus.pc, 20'h00400 + 20'(k * 16));
      clear();
      chk("nest_depth", 20'(bus.depth), 20'(k + 1));
      tick();
    end
    chk("nest_fault", 20'(bus.fault), 20'h0);

    // fifth call overflows
    bus.ins_vld = 1'b1; bus.call = 1'b1; bus.tgt = 20'h00500;
    #1 chk("ovf_ena", 20'(bus.stk_ena), 20'h0);
    tick();
    clear();
    chk("ovf_fault", 20'(bus.fault), 20'h1);
    chk("ovf_depth", 20'(bus.depth), 20'h4);
    chk("ovf_pc", bus.pc, TRAP ? 20'hFFFF0 : 20'h00500);
    chk("ovf_flush", 20'(bus.flush), 20'h1);
    tick();

    // wrap of the fetch address
    bus.ins_vld = 1'b1; bus.jmp = 1'b1; bus.cond = 1'b1; bus.tgt = 20'hFFFFF;
    tick();
    clear();
    chk("wrap_pc", bus.pc, 20'hFFFFF);
    tick();
    chk("wrap_pc2", bus.pc, 20'h00000);

    // reset while in BUBBLE
    bus.ins_vld = 1'b1; bus.jmp = 1'b1; bus.cond = 1'b1; bus.tgt = 20'h00700;
    tick();
    clear();
    chk("bub_pc", bus.pc, 20'h00700);
    rst = 1'b1;
    bus.ins_vld = 1'b1; bus.call = 1'b1; bus.tgt = 20'h00900;
    #1 chk("bubrst_ena", 20'(bus.stk_ena), 20'h0);
    tick();
    rst = 1'b0;
    clear();
    chk("bubrst_pc", bus.pc, 20'h0);
    chk("bubrst_depth", 20'(bus.depth), 20'h0);
    chk("bubrst_fault", 20'(bus.fault), 20'h0);
    chk("bubrst_flush", 20'(bus.flush), 20'h1);
    tick();

    // return with an empty stack
    bus.ins_vld = 1'b1; bus.ret = 1'b1; bus.stk_do = 20'h00055;
    #1 chk("unf_rts", 20'(bus.stk_rts), 20'h0);
    tick();
    clear();
    chk("unf_fault", 20'(bus.fault), 20'h1);
    chk("unf_depth", 20'(bus.depth), 20'h0);
    chk("unf_pc", bus.pc, TRAP ? 20'hFFFF0 : 20'h00002);
    chk("unf_flush", 20'(bus.flush), TRAP ? 20'h1 : 20'h0);
    tick();
    p0 = TRAP ? 20'hFFFF1 : 20'h00003;
    chk("unf_pc2", bus.pc, p0);

    // stall with a call pending
    bus.stall = 1'b1; bus.ins_vld = 1'b1; bus.call = 1'b1; bus.tgt = 20'h00800;
    for (int s = 0; s < 3; s++) begin
      #1 chk("stall_ena", 20'(bus.stk_ena), 20'h0);
      tick();
      chk("stall_pc", bus.pc, p0);
      chk("stall_depth", 20'(bus.depth), 20'h0);
      chk("stall_fault", 20'(bus.fault), 20'h1);
    end
    bus.stall = 1'b0;
    #1;
    chk("rel_ena", 20'(bus.stk_ena), 20'h1);
    chk("rel_di", bus.stk_di, p0);
    tick();
    clear();
    chk("rel_pc", bus.pc, 20'h00800);
    chk("rel_depth", 20'(bus.depth), 20'h1);
    #1 chk("rel_ena2", 20'(bus.stk_ena), 20'h0);
    tick();
    chk("rel_depth2", 20'(bus.depth), 20'h1);
    chk("rel_pc2", bus.pc, 20'h00801);

    // reset in RUN with a call pending
    rst = 1'b1;
    bus.ins_vld = 1'b1; bus.call = 1'b1; bus.tgt = 20'h00A00;
    #1 chk("runrst_ena", 20'(bus.stk_ena), 20'h0);
    tick();
    rst = 1'b0;
    clear();
    chk("runrst_pc", bus.pc, 20'h0);
    chk("runrst_depth", 20'(bus.depth), 20'h0);
    chk("runrst_fault", 20'(bus.fault), 20'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
